// File: rtl/vpu_line_sched.sv
// Per-scanline DMA scheduler: programs the VPU cache/DMA registers on every line start
// and shares the single VPU register port between the CPU and the sequencer.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | port owned by the CPU, waiting for an enabled line_start
// S_W0..W1  | write cache pointer (regs 0,1) to zero
// S_W2..W3  | write DMA source address hi/lo (regs C,D) from line_addr
// S_W4      | write DMA step (reg E) = 1
// S_W5      | write DMA length (reg F) = LINE_LEN
// S_WAIT_UP | waiting for vpu_hold to rise, bounded by HOLD_TIMEOUT
// S_WAIT_DN | waiting for vpu_hold to fall
// S_DONE    | advance line_addr by STRIDE, or reload BASE after a frame start
module vpu_line_sched #(
    parameter int LINE_LEN     = 40,
    parameter int DEF_STRIDE   = 40,
    parameter int HOLD_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_start,
    input  logic       frame_start,
    input  logic       cpu_cs,
    input  logic       cpu_rw,
    input  logic [3:0] cpu_ad,
    input  logic [7:0] cpu_di,
    output logic       cpu_wait,
    input  logic       cfg_cs,
    input  logic       cfg_rw,
    input  logic [1:0] cfg_ad,
    input  logic [7:0] cfg_di,
    output logic [7:0] cfg_do,
    output logic       vpu_cs,
    output logic       vpu_rw,
    output logic [3:0] vpu_ad,
    output logic [7:0] vpu_di,
    input  logic       vpu_hold
);

    localparam int CW = (HOLD_TIMEOUT < 1) ? 1 : $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LOAD = CW'(HOLD_TIMEOUT - 1);
    localparam logic [7:0] LEN8 = 8'(LINE_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_W0, S_W1, S_W2, S_W3, S_W4, S_W5, S_WAIT_UP, S_WAIT_DN, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [15:0]   base, line_addr;
    logic [7:0]    stride;
    logic          en, ovr, tmo, frame_pend;
    logic [CW-1:0] cnt;
    logic          idle, ls_accept, ls_over, tmo_set, ctrl_rd, cfg_wr;
    logic          fsm_cs;
    logic [3:0]    fsm_ad;
    logic [7:0]    fsm_di;
    logic [7:0]    cfg_rd_data;

    assign idle      = (state == S_IDLE);
    assign ls_accept = line_start && en && idle;
    assign ls_over   = line_start && en && !idle;
    assign cfg_wr    = cfg_cs && !cfg_rw;
    assign ctrl_rd   = cfg_cs && cfg_rw && (cfg_ad == 2'd3);
    assign tmo_set   = (state == S_WAIT_UP) && !vpu_hold && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fsm_cs    = 1'b1;
        fsm_ad    = 4'h0;
        fsm_di    = 8'h00;
        case (state)
            S_IDLE: begin
                fsm_cs = 1'b0;
                if (ls_accept) state_nxt = S_W0;
            end
            S_W0: state_nxt = S_W1;
            S_W1: begin
                fsm_ad    = 4'h1;
                state_nxt = S_W2;
            end
            S_W2: begin
                fsm_ad    = 4'hC;
                fsm_di    = line_addr[15:8];
                state_nxt = S_W3;
            end
            S_W3: begin
                fsm_ad    = 4'hD;
                fsm_di    = line_addr[7:0];
                state_nxt = S_W4;
            end
            S_W4: begin
                fsm_ad    = 4'hE;
                fsm_di    = 8'h01;
                state_nxt = S_W5;
            end
            S_W5: begin
                fsm_ad    = 4'hF;
                fsm_di    = LEN8;
                state_nxt = (LINE_LEN == 0) ? S_DONE : S_WAIT_UP;
            end
            S_WAIT_UP: begin
                fsm_cs = 1'b0;
                if (vpu_hold)        state_nxt = S_WAIT_DN;
                else if (cnt == '0)  state_nxt = S_DONE;
            end
            S_WAIT_DN: begin
                fsm_cs = 1'b0;
                if (!vpu_hold) state_nxt = S_DONE;
            end
            S_DONE: begin
                fsm_cs    = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                fsm_cs    = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // The CPU owns the port only while the sequencer is idle.
    always_comb begin
        if (idle) begin
            vpu_cs   = cpu_cs;
            vpu_rw   = cpu_rw;
            vpu_ad   = cpu_ad;
            vpu_di   = cpu_di;
            cpu_wait = 1'b0;
        end else begin
            vpu_cs   = fsm_cs;
            vpu_rw   = !fsm_cs;
            vpu_ad   = fsm_ad;
            vpu_di   = fsm_di;
            cpu_wait = cpu_cs;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                cnt <= '0;
        else if (state == S_W5)                  cnt <= TMO_LOAD;
        else if (state == S_WAIT_UP && cnt != '0) cnt <= cnt - CW'(1);
    end

    // A frame start seen mid-sequence is deferred to DONE so the running line keeps its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_addr  <= 16'h0000;
            frame_pend <= 1'b0;
        end else if (state == S_DONE) begin
            line_addr  <= (frame_pend || frame_start) ? base : line_addr + {8'h00, stride};
            frame_pend <= 1'b0;
        end else if (frame_start) begin
            if (idle) line_addr  <= base;
            else      frame_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base   <= 16'h0000;
            stride <= 8'(DEF_STRIDE);
            en     <= 1'b0;
        end else if (cfg_wr) begin
            case (cfg_ad)
                2'd0: base[15:8] <= cfg_di;
                2'd1: base[7:0]  <= cfg_di;
                2'd2: stride     <= cfg_di;
                2'd3: en         <= cfg_di[7];
                default: ;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as a CTRL read survives the read-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr <= 1'b0;
            tmo <= 1'b0;
        end else begin
            ovr <= ls_over | (ovr & !ctrl_rd);
            tmo <= tmo_set | (tmo & !ctrl_rd);
        end
    end

    always_comb begin
        cfg_rd_data = 8'h00;
        case (cfg_ad)
            2'd0: cfg_rd_data = base[15:8];
            2'd1: cfg_rd_data = base[7:0];
            2'd2: cfg_rd_data = stride;
            2'd3: cfg_rd_data = {en, !idle, ovr, tmo, 4'b0000};
            default: cfg_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 cfg_do <= 8'h00;
        else if (cfg_cs && cfg_rw) cfg_do <= cfg_rd_data;
    end

endmodule

// File: tb/tb_vpu_line_sched.sv
// Bench for vpu_line_sched: scripted and randomized line sequences checked against
// a table-driven model of the six-write sequence and a plain-arithmetic line address.
module tb_vpu_line_sched;
    localparam int LINE_LEN   = 40;
    localparam int DEF_STRIDE = 40;
    localparam int BIG        = 1000000;

    logic       clk = 1'b0, rst = 1'b0;
    logic       line_start = 1'b0, frame_start = 1'b0;
    logic       cpu_cs = 1'b0, cpu_rw = 1'b1;
    logic [3:0] cpu_ad = 4'h0;
    logic [7:0] cpu_di = 8'h00;
    logic       cpu_wait;
    logic       cfg_cs = 1'b0, cfg_rw = 1'b1;
    logic [1:0] cfg_ad = 2'd0;
    logic [7:0] cfg_di = 8'h00;
    logic [7:0] cfg_do;
    logic       vpu_cs, vpu_rw;
    logic [3:0] vpu_ad;
    logic [7:0] vpu_di;
    logic       vpu_hold = 1'b0;

    int vectors = 0, errors = 0;
    int cyc_cnt = 0;
    int hold_start = BIG, hold_len = 80;
    bit hold_auto = 1'b1;

    typedef struct { logic [3:0] ad; logic [7:0] di; int cyc; } wr_t;
    wr_t wq[$];

    logic [15:0] m_base = 16'h0000, m_addr = 16'h0000;
    logic [7:0]  m_stride = 8'(DEF_STRIDE);

    vpu_line_sched #(.LINE_LEN(LINE_LEN), .DEF_STRIDE(DEF_STRIDE), .HOLD_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .frame_start(frame_start),
        .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_ad(cpu_ad), .cpu_di(cpu_di), .cpu_wait(cpu_wait),
        .cfg_cs(cfg_cs), .cfg_rw(cfg_rw), .cfg_ad(cfg_ad), .cfg_di(cfg_di), .cfg_do(cfg_do),
        .vpu_cs(vpu_cs), .vpu_rw(vpu_rw), .vpu_ad(vpu_ad), .vpu_di(vpu_di), .vpu_hold(vpu_hold)
    );

    always #5 clk = ~clk;

    // Record every VPU write, numbered by cycle; the VPU model raises hold two cycles after the length write.
    initial forever begin
        @(negedge clk);
        #2;
        cyc_cnt++;
        if (vpu_cs === 1'b1 && vpu_rw === 1'b0) begin
            wq.push_back('{ad: vpu_ad, di: vpu_di, cyc: cyc_cnt});
            if (vpu_ad == 4'hF) hold_start = cyc_cnt + 2;
        end
    end

    initial forever begin
        @(negedge clk);
        vpu_hold = hold_auto && (cyc_cnt + 1 >= hold_start) && (cyc_cnt + 1 < hold_start + hold_len);
    end

    function automatic logic [11:0] exp_wr(input int i, input logic [15:0] a);
        case (i)
            0: return {4'h0, 8'h00};
            1: return {4'h1, 8'h00};
            2: return {4'hC, a[15:8]};
            3: return {4'hD, a[7:0]};
            4: return {4'hE, 8'h01};
            default: return {4'hF, 8'(LINE_LEN)};
        endcase
    endfunction

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); cfg_cs = 1'b1; cfg_rw = 1'b0; cfg_ad = a; cfg_di = d;
        @(negedge clk); cfg_cs = 1'b0; cfg_rw = 1'b1;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); cfg_cs = 1'b1; cfg_rw = 1'b1; cfg_ad = a;
        @(negedge clk); cfg_cs = 1'b0;
        #3 d = cfg_do;
    endtask

    task automatic set_base(input logic [15:0] b);
        cfg_write(2'd0, b[15:8]);
        cfg_write(2'd1, b[7:0]);
        m_base = b;
    endtask

    task automatic set_stride(input logic [7:0] s);
        cfg_write(2'd2, s);
        m_stride = s;
    endtask

    task automatic frame_pulse();
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
        m_addr = m_base;
    endtask

    // Pulse line_start (optionally with frame_start), then run 'cycles' more cycles,
    // re-pulsing line_start at relative cycle extra_at if nonzero.
    task automatic run_line(input bit frame, input int extra_at, input int cycles, output int n);
        @(negedge clk); line_start = 1'b1; frame_start = frame;
        #3 n = cyc_cnt;
        for (int t = 1; t <= cycles; t++) begin
            @(negedge clk);
            line_start  = (t == extra_at);
            frame_start = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b0;
        tick(3);
        #3;
        vectors++;
        if ({vpu_cs, vpu_rw, vpu_ad, vpu_di, cpu_wait, cfg_do} !== {1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got cs=%b rw=%b ad=%h di=%h wait=%b cfg_do=%h, want 0 1 0 00 0 00",
                     vpu_cs, vpu_rw, vpu_ad, vpu_di, cpu_wait, cfg_do);
        end
        @(negedge clk); rst = 1'b1;
        tick(2);
        for (int a = 0; a < 4; a++) begin
            logic [7:0] want;
            want = (a == 2) ? 8'(DEF_STRIDE) : 8'h00;
            cfg_read(2'(a), d);
            vectors++;
            if (d !== want) begin
                errors++;
                $display("FAIL reset_cfg[%0d]: got %h, want %h", a, d, want);
            end
        end
        @(negedge clk); cpu_cs = 1'b1; cpu_rw = 1'b1; cpu_ad = 4'h9;
        #3;
        vectors++;
        if ({vpu_cs, vpu_rw, vpu_ad, cpu_wait} !== {1'b1, 1'b1, 4'h9, 1'b0}) begin
            errors++;
            $display("FAIL idle_passthru: got cs=%b rw=%b ad=%h wait=%b, want 1 1 9 0", vpu_cs, vpu_rw, vpu_ad, cpu_wait);
        end
        @(negedge clk); cpu_cs = 1'b0; cpu_ad = 4'h0;
    endtask

    task automatic test_basic();
        int n;
        logic [7:0] d;
        logic [11:0] e;
        set_base(16'h4000);
        set_stride(8'd40);
        cfg_write(2'd3, 8'h80);
        hold_len = 80; hold_start = BIG; wq.delete();
        m_addr = m_base;
        run_line(1'b1, 0, 92, n);
        vectors++;
        if (wq.size() != 6) begin
            errors++;
            $display("FAIL basic_count: got %0d writes, want 6", wq.size());
        end
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            e = exp_wr(i, m_addr);
            vectors++;
            if ({wq[i].ad, wq[i].di} !== e || wq[i].cyc != n + 1 + i) begin
                errors++;
                $display("FAIL basic_wr[%0d]: got %h@%0d, want %h@%0d", i, {wq[i].ad, wq[i].di}, wq[i].cyc, e, n + 1 + i);
            end
        end
        m_addr = m_addr + 16'(m_stride);
        cfg_read(2'd3, d);
        vectors++;
        if (d !== 8'h80) begin
            errors++;
            $display("FAIL basic_idle_ctrl: got %h, want 80", d);
        end
    endtask

    task automatic test_sequence();
        int n;
        logic [11:0] e;
        frame_pulse();
        for (int k = 0; k < 4; k++) begin
            if (k == 3) frame_pulse();
            hold_len = $urandom_range(1, 10); hold_start = BIG; wq.delete();
            run_line(1'b0, 0, hold_len + 12, n);
            vectors++;
            if (wq.size() != 6) begin
                errors++;
                $display("FAIL seq_count[%0d]: got %0d, want 6", k, wq.size());
            end
            for (int i = 0; i < 6 && i < wq.size(); i++) begin
                e = exp_wr(i, m_addr);
                vectors++;
                if ({wq[i].ad, wq[i].di} !== e) begin
                    errors++;
                    $display("FAIL seq_wr[%0d][%0d]: got %h, want %h", k, i, {wq[i].ad, wq[i].di}, e);
                end
            end
            m_addr = m_addr + 16'(m_stride);
        end
    endtask

    task automatic test_cpu_stall();
        int n, rel, stalls, hits, hit_cyc;
        logic [7:0] x, y;
        x = 8'($urandom); y = 8'($urandom);
        hold_len = 20; hold_start = BIG; wq.delete();
        @(negedge clk); line_start = 1'b1; cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_ad = 4'h5; cpu_di = x;
        #3 n = cyc_cnt;
        vectors++;
        if ({vpu_cs, vpu_rw, vpu_ad, vpu_di, cpu_wait} !== {1'b1, 1'b0, 4'h5, x, 1'b0}) begin
            errors++;
            $display("FAIL stall_same_cycle: got cs=%b rw=%b ad=%h di=%h wait=%b, want 1 0 5 %h 0",
                     vpu_cs, vpu_rw, vpu_ad, vpu_di, cpu_wait, x);
        end
        @(negedge clk); line_start = 1'b0; cpu_cs = 1'b0; cpu_rw = 1'b1;
        #3;
        vectors++;
        if ({vpu_cs, vpu_ad, cpu_wait} !== {1'b1, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL stall_w0_owner: got cs=%b ad=%h wait=%b, want 1 0 0", vpu_cs, vpu_ad, cpu_wait);
        end
        tick(2);
        @(negedge clk); cpu_cs = 1'b1; cpu_rw = 1'b0; cpu_ad = 4'h2; cpu_di = y;
        rel = -1; stalls = 0;
        for (int t = 0; t < 300 && rel < 0; t++) begin
            if (t > 0) @(negedge clk);
            #3;
            if (cpu_wait === 1'b1) stalls++;
            else rel = cyc_cnt;
        end
        @(negedge clk); cpu_cs = 1'b0; cpu_rw = 1'b1; cpu_ad = 4'h0; cpu_di = 8'h00;
        vectors++;
        if (rel != n + hold_len + 10 || stalls != hold_len + 6) begin
            errors++;
            $display("FAIL stall_release: got cycle %0d after %0d stalls, want %0d after %0d",
                     rel - n, stalls, hold_len + 10, hold_len + 6);
        end
        hits = 0; hit_cyc = -1;
        foreach (wq[i]) if (wq[i].ad == 4'h2) begin hits++; hit_cyc = wq[i].cyc; end
        vectors++;
        if (hits != 1 || hit_cyc != rel || wq.size() != 8) begin
            errors++;
            $display("FAIL stall_cpu_write: got %0d hits at %0d, %0d writes total, want 1 at %0d, 8 total",
                     hits, hit_cyc, wq.size(), rel);
        end
        foreach (wq[i]) if (wq[i].ad == 4'h2) begin
            vectors++;
            if (wq[i].di !== y) begin
                errors++;
                $display("FAIL stall_cpu_data: got %h, want %h", wq[i].di, y);
            end
        end
        m_addr = m_addr + 16'(m_stride);
    endtask

    task automatic test_overrun();
        int n;
        logic [7:0] d;
        hold_len = 30; hold_start = BIG; wq.delete();
        run_line(1'b0, 20, 42, n);
        vectors++;
        if (wq.size() != 6) begin
            errors++;
            $display("FAIL ovr_count: got %0d writes, want 6", wq.size());
        end
        m_addr = m_addr + 16'(m_stride);
        cfg_read(2'd3, d);
        vectors++;
        if (d !== 8'hA0) begin errors++; $display("FAIL ovr_read1: got %h, want a0", d); end
        cfg_read(2'd3, d);
        vectors++;
        if (d !== 8'h80) begin errors++; $display("FAIL ovr_read2: got %h, want 80", d); end
    endtask

    task automatic test_timeout();
        int n;
        logic [7:0] d;
        logic [11:0] e;
        hold_auto = 1'b0; hold_start = BIG; wq.delete();
        run_line(1'b0, 0, 250, n);
        cfg_read(2'd3, d);
        vectors++;
        if (d !== 8'hC0) begin errors++; $display("FAIL tmo_waiting: got %h, want c0", d); end
        tick(15);
        cfg_read(2'd3, d);
        vectors++;
        if (d !== 8'h90) begin errors++; $display("FAIL tmo_flag: got %h, want 90", d); end
        cfg_read(2'd3, d);
        vectors++;
        if (d !== 8'h80) begin errors++; $display("FAIL tmo_clear: got %h, want 80", d); end
        vectors++;
        if (wq.size() != 6) begin errors++; $display("FAIL tmo_count: got %0d, want 6", wq.size()); end
        m_addr = m_addr + 16'(m_stride);
        hold_auto = 1'b1; hold_len = 5; hold_start = BIG; wq.delete();
        run_line(1'b0, 0, 17, n);
        for (int i = 2; i < 4 && i < wq.size(); i++) begin
            e = exp_wr(i, m_addr);
            vectors++;
            if ({wq[i].ad, wq[i].di} !== e) begin
                errors++;
                $display("FAIL tmo_advance[%0d]: got %h, want %h", i, {wq[i].ad, wq[i].di}, e);
            end
        end
        m_addr = m_addr + 16'(m_stride);
    endtask

    task automatic test_wrap();
        int n;
        logic [11:0] e;
        set_base(16'hFFF0);
        set_stride(8'h20);
        m_addr = m_base;
        for (int k = 0; k < 2; k++) begin
            hold_len = 3; hold_start = BIG; wq.delete();
            run_line(k == 0, 0, 15, n);
            vectors++;
            if (wq.size() != 6) begin errors++; $display("FAIL wrap_count[%0d]: got %0d, want 6", k, wq.size()); end
            for (int i = 0; i < 6 && i < wq.size(); i++) begin
                e = exp_wr(i, m_addr);
                vectors++;
                if ({wq[i].ad, wq[i].di} !== e) begin
                    errors++;
                    $display("FAIL wrap_wr[%0d][%0d]: got %h, want %h", k, i, {wq[i].ad, wq[i].di}, e);
                end
            end
            m_addr = m_addr + 16'(m_stride);
        end
    endtask

    task automatic test_en();
        int n;
        logic [7:0] d;
        hold_len = 30; hold_start = BIG; wq.delete();
        run_line(1'b0, 0, 12, n);
        cfg_write(2'd3, 8'h00);
        tick(30);
        vectors++;
        if (wq.size() != 6 || wq[2].di !== m_addr[15:8] || wq[3].di !== m_addr[7:0]) begin
            errors++;
            $display("FAIL en_clear_completes: got %0d writes, want 6 with addr %h", wq.size(), m_addr);
        end
        m_addr = m_addr + 16'(m_stride);
        cfg_read(2'd3, d);
        vectors++;
        if (d !== 8'h00) begin errors++; $display("FAIL en_ctrl: got %h, want 00", d); end
        wq.delete();
        run_line(1'b0, 0, 10, n);
        cfg_read(2'd3, d);
        vectors++;
        if (wq.size() != 0 || d !== 8'h00) begin
            errors++;
            $display("FAIL en_ignored: got %0d writes ctrl=%h, want 0 writes ctrl=00", wq.size(), d);
        end
        cfg_write(2'd3, 8'h80);
    endtask

    task automatic test_random();
        int n;
        bit fr;
        logic [11:0] e;
        for (int k = 0; k < 6; k++) begin
            set_base(16'($urandom));
            set_stride(8'($urandom));
            fr = (k == 0) || ($urandom_range(0, 1) == 1);
            if (fr) m_addr = m_base;
            hold_len = $urandom_range(1, 20); hold_start = BIG; wq.delete();
            run_line(fr, 0, hold_len + 12, n);
            vectors++;
            if (wq.size() != 6) begin errors++; $display("FAIL rnd_count[%0d]: got %0d, want 6", k, wq.size()); end
            for (int i = 0; i < 6 && i < wq.size(); i++) begin
                e = exp_wr(i, m_addr);
                vectors++;
                if ({wq[i].ad, wq[i].di} !== e || wq[i].cyc != n + 1 + i) begin
                    errors++;
                    $display("FAIL rnd_wr[%0d][%0d]: got %h@%0d, want %h@%0d", k, i,
                             {wq[i].ad, wq[i].di}, wq[i].cyc - n, e, 1 + i);
                end
            end
            m_addr = m_addr + 16'(m_stride);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [7:0] d;
        hold_len = 10; hold_start = BIG; wq.delete();
        @(negedge clk); line_start = 1'b1;
        #3 n = cyc_cnt;
        @(negedge clk); line_start = 1'b0;
        tick(1);
        @(negedge clk); rst = 1'b0;
        #3;
        vectors++;
        if ({vpu_cs, vpu_rw, vpu_ad, vpu_di, cpu_wait, cfg_do} !== {1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rst_mid_outputs: got cs=%b rw=%b ad=%h di=%h wait=%b cfg_do=%h, want 0 1 0 00 0 00",
                     vpu_cs, vpu_rw, vpu_ad, vpu_di, cpu_wait, cfg_do);
        end
        tick(2);
        @(negedge clk); rst = 1'b1;
        tick(3);
        vectors++;
        if (wq.size() != 2) begin errors++; $display("FAIL rst_mid_writes: got %0d writes, want 2", wq.size()); end
        for (int a = 0; a < 4; a++) begin
            logic [7:0] want;
            want = (a == 2) ? 8'(DEF_STRIDE) : 8'h00;
            cfg_read(2'(a), d);
            vectors++;
            if (d !== want) begin errors++; $display("FAIL rst_mid_cfg[%0d]: got %h, want %h", a, d, want); end
        end
        wq.delete();
        run_line(1'b0, 0, 10, n);
        vectors++;
        if (wq.size() != 0) begin errors++; $display("FAIL rst_mid_disabled: got %0d writes, want 0", wq.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_cpu_stall();
        test_overrun();
        test_timeout();
        test_wrap();
        test_en();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
